// File: rtl/display_scan_controller.sv
// Multiplexed hex display scanner: one shared decoder, N digits.
// Blanking gap per slot, optional leading-zero suppression.
module display_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int ADDR_W       = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  lz_blank,
  output logic [3:0]            nibble_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_BLK_END =
    CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_END =
    CNT_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST =
    ADDR_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic [3:0]            regs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp;
  logic                  lz_q;

  logic                  zero_above;
  logic [NUM_DIGITS-1:0] supp;

  // Scan state register: state, digit index, slot counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  // Digit register file; lz_blank is registered to keep outputs Moore.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        regs[i] <= 4'h0;
      end
      dp   <= '0;
      lz_q <= 1'b0;
    end else begin
      lz_q <= lz_blank;
      if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
        regs[wr_addr] <= wr_data;
        dp[wr_addr]   <= wr_dp;
      end
    end
  end

  // Next-state: blank gap, then show, then advance to next digit.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = BLANK;
          idx_n   = '0;
          cnt_n   = '0;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_BLK_END) begin
            state_n = SHOW;
          end
        end
      end
      SHOW: begin
        if (!enable) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (cnt == CNT_SLOT_END) begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // A digit is a leading zero if it and every higher digit hold 0.
  always_comb begin
    zero_above = 1'b1;
    supp       = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (regs[i] == 4'h0);
      supp[i]    = lz_q && zero_above;
    end
  end

  // Outputs from registered state only.
  always_comb begin
    nibble_out = 4'h0;
    dp_out     = 1'b0;
    digit_en   = '0;
    blank      = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      BLANK: begin
        nibble_out = regs[idx];
      end
      SHOW: begin
        nibble_out = regs[idx];
        frame_done = (cnt == CNT_SLOT_END) && (idx == IDX_LAST);
        if (!supp[idx]) begin
          dp_out   = dp[idx];
          digit_en = NUM_DIGITS'(1) << idx;
          blank    = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: scoreboard vs. frame-time model.
// Model tracks time-into-frame and derives digit/phase arithmetically.
module tb_display_scan_controller;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int AW  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]   wr_data;
  logic         wr_dp;
  logic         lz_blank;
  logic [3:0]   nibble_out;
  logic         dp_out;
  logic [N-1:0] digit_en;
  logic         blank;
  logic         frame_done;

  always #5 clk = ~clk;

  display_scan_controller #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .lz_blank  (lz_blank),
    .nibble_out(nibble_out),
    .dp_out    (dp_out),
    .digit_en  (digit_en),
    .blank     (blank),
    .frame_done(frame_done)
  );

  // Reference model state
  logic [3:0] mreg [N];
  logic       mdp  [N];
  bit         run;
  int         t;
  bit         mlz;

  logic [10:0] sb [$];
  int passed = 0;
  int total  = 0;

  function automatic logic [10:0] expect_out();
    logic [3:0]   nib;
    logic         d;
    logic [N-1:0] en;
    logic         b;
    logic         fd;
    int           dig;
    int           pos;
    bit           sup;
    if (!run) return {4'h0, 1'b0, {N{1'b0}}, 1'b1, 1'b0};
    dig = t / DIV;
    pos = t % DIV;
    nib = mreg[dig];
    fd  = (t == N * DIV - 1);
    sup = 1'b0;
    if (mlz && dig > 0) begin
      sup = 1'b1;
      for (int j = dig; j < N; j++) begin
        if (mreg[j] != 4'h0) sup = 1'b0;
      end
    end
    if (pos < BLK || sup) begin
      d  = 1'b0;
      en = '0;
      b  = 1'b1;
    end else begin
      d  = mdp[dig];
      en = N'(1) << dig;
      b  = 1'b0;
    end
    return {nib, d, en, b, fd};
  endfunction

  function automatic void model_edge();
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mreg[i] = 4'h0;
        mdp[i]  = 1'b0;
      end
      run = 1'b0;
      t   = 0;
      mlz = 1'b0;
    end else begin
      mlz = lz_blank;
      if (wr_en && int'(wr_addr) < N) begin
        mreg[wr_addr] = wr_data;
        mdp[wr_addr]  = wr_dp;
      end
      if (!enable) begin
        run = 1'b0;
        t   = 0;
      end else if (!run) begin
        run = 1'b1;
        t   = 0;
      end else begin
        t = (t + 1) % (N * DIV);
      end
    end
  endfunction

  // One clock: model the edge, queue expectation, return at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    sb.push_back(expect_out());
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d, input bit p);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = 4'(d);
    wr_dp   = p;
    step();
    wr_en   = 1'b0;
  endtask

  // Monitor: compare DUT outputs away from the active edge.
  always @(negedge clk) begin
    logic [10:0] exp_v;
    logic [10:0] got;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      got   = {nibble_out, dp_out, digit_en, blank, frame_done};
      total++;
      if (got === exp_v) begin
        passed++;
      end else begin
        $display("FAIL outputs @%0t: got nib=%h dp=%b en=%b blank=%b fd=%b, expected nib=%h dp=%b en=%b blank=%b fd=%b",
                 $time, got[10:7], got[6], got[5:2], got[1], got[0],
                 exp_v[10:7], exp_v[6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = '0;
    wr_data  = 4'hF;
    wr_dp    = 1'b1;
    lz_blank = 1'b0;
    step();
    step();
    rst    = 1'b0;
    wr_en  = 1'b0;
    enable = 1'b0;
    step();

    // Full scan
    for (int i = 0; i < N; i++) wr(i, i + 1, 1'b0);
    enable = 1'b1;
    repeat (70) step();

    // Leading zeros
    enable = 1'b0;
    step();
    wr(0, 0, 1'b0);
    wr(1, 5, 1'b1);
    wr(2, 0, 1'b1);
    wr(3, 0, 1'b0);
    lz_blank = 1'b1;
    enable   = 1'b1;
    repeat (34) step();
    wr(1, 0, 1'b0);
    repeat (34) step();

    // Live write during SHOW of digit 2
    enable = 1'b0;
    step();
    lz_blank = 1'b0;
    enable   = 1'b1;
    repeat (2 * DIV + 4) step();
    wr(2, 4'hA, 1'b1);
    repeat (20) step();

    // Abort mid-SHOW of digit 1, then re-enable
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (DIV + BLK + 3) step();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    repeat (12) step();

    // Mid-frame reset during SHOW of digit 3
    enable = 1'b0;
    step();
    wr(3, 7, 1'b1);
    enable = 1'b1;
    repeat (3 * DIV + 4) step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (40) step();

    // Randomized traffic
    repeat (600) begin
      rst     = ($urandom_range(0, 99) == 0);
      enable  = ($urandom_range(0, 19) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, N - 1));
      wr_data = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      wr_dp   = 1'($urandom);
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      step();
    end
    rst   = 1'b0;
    wr_en = 1'b0;

    @(posedge clk);
    @(negedge clk);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
